timer_event_logger: RTL and testbench
=====================================

TIMER_EVENT_LOGGER -- requirements
Module: timer_event_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the event FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset_n, input, 1, the reset: synchronous and active-low.
REQ-004 The block SHALL have port timer_irq, input, 1, the interval-timer interrupt level (synchronous to clk).
REQ-005 The block SHALL have port address, input, 3, the Avalon-MM slave register index.
REQ-006 The block SHALL have port chipselect, input, 1, the slave select.
REQ-007 The block SHALL have ports read_n and write_n, input, 1 each, the active-low read and write strobes.
REQ-008 The block SHALL have port writedata, input, 16, the write data.
REQ-009 The block SHALL have port readdata, output, 16, the registered read data.
REQ-010 The block SHALL have port irq, output, 1, the event-pending interrupt.

Function
REQ-011 The block SHALL run a 32-bit free-running timestamp counter (ts) that increments every cycle and wraps from 0xFFFFFFFF to 0.
REQ-012 The block SHALL register timer_irq as irq_d and detect an event as timer_irq & ~irq_d & ctrl_en; a held-high level SHALL produce one event only.
REQ-013 On an event, the block SHALL push the ts value of the event cycle into the FIFO tail.
REQ-014 The register map SHALL be as follows:
- 0 STATUS: read {8'b0, count[3:0], 1'b0, ovf, full, empty}; a write of any value clears ovf.
- 1 CONTROL: bit0 ctrl_en, bit1 irq_en, bit2 flush (write-only, self-clearing); reads return {14'b0, irq_en, ctrl_en}.
- 2 DATA_L: returns head[15:0], with no side effect.
- 3 DATA_H: returns head[31:16] and pops the head.
- 4 SNAP_L and 5 SNAP_H: read the ts snapshot; a write of any value to either captures ts.
- 6 DROPS: 16-bit drop counter; a write of any value clears it.
- 7: reads return 0.
REQ-015 readdata SHALL be registered with one-cycle latency: it is updated every cycle from the address-selected mux, regardless of read_n.
REQ-016 A pop SHALL occur when chipselect && ~read_n && address==3 && ~empty; readdata SHALL carry the pre-pop head.
REQ-017 A pop or a DATA read while the FIFO is empty SHALL return 0 and SHALL leave the state unchanged.
REQ-018 An event while full without a same-cycle pop SHALL be dropped: ovf is set and DROPS increments, saturating at 0xFFFF.
REQ-019 An event while full with a same-cycle pop SHALL push and pop together: count is unchanged and no drop is recorded.
REQ-020 A simultaneous push and pop at any other count SHALL leave count unchanged, with both pointers advancing modulo DEPTH.
REQ-021 A flush SHALL zero count and both pointers in the next cycle; a same-cycle event or pop SHALL be discarded, with no drop counted and ovf/DROPS unaffected.
REQ-022 A DROPS clear coincident with a drop SHALL result in DROPS = 0.
REQ-023 An ovf clear coincident with a drop SHALL result in ovf = 1.
REQ-024 The flags SHALL be defined as empty = (count==0) and full = (count==DEPTH), with count 0..DEPTH.
REQ-025 irq SHALL be registered and equal irq_en && ~empty of the prior cycle.
REQ-026 Clearing ctrl_en SHALL stop new pushes only; the FIFO contents and irq_d tracking SHALL continue.

Reset
REQ-027 While reset_n is low at a clk edge, the block SHALL set to zero: ts, count, the pointers, ovf, DROPS, the snapshot, ctrl_en, irq_en, irq_d, readdata and irq.
REQ-028 The FIFO storage SHALL NOT require reset; reads while empty SHALL be masked to 0.
REQ-029 A reset asserted mid-operation SHALL discard all stored events and any in-flight pop.

Verification
REQ-030 Event capture: write CONTROL=0x0003, then pulse timer_irq high at ts=100 -> STATUS reads 0x0010, irq=1, DATA_L=0x0064, DATA_H=0x0000, then STATUS=0x0001 and irq=0.
REQ-031 Overflow: with DEPTH=8, generate 10 rising edges with no reads -> STATUS=0x0086, DROPS=2; after writing STATUS, ovf=0 and DROPS stays 2.
REQ-032 Full with simultaneous pop: at full, coincide an event with a DATA_H read -> count stays 8, DROPS unchanged, the new timestamp appears last.
REQ-033 Flush: at count=3, write CONTROL=0x0007 in the same cycle as an event -> STATUS=0x0001, DROPS=0, irq=0.
REQ-034 Edge-only capture: hold timer_irq high for 50 cycles -> exactly one entry is stored.
REQ-035 Snapshot and empty read: force ts=0xFFFFFFFE, write SNAP_L, wait 5 cycles -> SNAP_L=0xFFFE, SNAP_H=0xFFFF; a DATA_H read while empty returns 0 with count 0.

Source files
------------

// File: rtl/timer_event_logger.sv
// Timer event logger: timestamps rising edges of timer_irq into a small FIFO
// and exposes it, a ts snapshot and a drop counter over an Avalon-MM slave.
module timer_event_logger #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        timer_irq,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   ts;
  logic [31:0]   snap;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [15:0]   drops;
  logic          ovf;
  logic          ctrl_en;
  logic          irq_en;
  logic          irq_d;

  logic          empty;
  logic          full;
  logic          rd_sel;
  logic          wr_sel;
  logic          evt;
  logic          flush;
  logic          pop;
  logic          push;
  logic          drop;
  logic [31:0]   head;
  logic [15:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[15:3];

  // Event, pop, push and drop qualification; flush discards same-cycle traffic.
  always_comb begin
    empty  = (count == '0);
    full   = (count == CW'(DEPTH));
    rd_sel = chipselect & ~read_n;
    wr_sel = chipselect & ~write_n;
    flush  = wr_sel && (address == 3'd1) && writedata[2];
    evt    = timer_irq & ~irq_d & ctrl_en;
    pop    = rd_sel && (address == 3'd3) && !empty && !flush;
    push   = evt && (!full || pop) && !flush;
    drop   = evt && full && !pop && !flush;
    head   = mem[rptr];
  end

  // Register read mux; FIFO data is masked to zero while empty.
  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0: rd_mux = {8'h00, 4'(count), 1'b0, ovf, full, empty};
      3'd1: rd_mux = {14'h0000, irq_en, ctrl_en};
      3'd2: rd_mux = empty ? 16'h0000 : head[15:0];
      3'd3: rd_mux = empty ? 16'h0000 : head[31:16];
      3'd4: rd_mux = snap[15:0];
      3'd5: rd_mux = snap[31:16];
      3'd6: rd_mux = drops;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts       <= 32'h0;
      snap     <= 32'h0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drops    <= 16'h0000;
      ovf      <= 1'b0;
      ctrl_en  <= 1'b0;
      irq_en   <= 1'b0;
      irq_d    <= 1'b0;
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      ts       <= ts + 32'd1;
      irq_d    <= timer_irq;
      readdata <= rd_mux;
      irq      <= irq_en & ~empty;

      if (flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end

      // A drop in the same cycle as an ovf clear wins.
      if (wr_sel && (address == 3'd0)) ovf <= 1'b0;
      if (drop) ovf <= 1'b1;

      // A DROPS clear in the same cycle as a drop wins.
      if (wr_sel && (address == 3'd6))     drops <= 16'h0000;
      else if (drop && drops != 16'hFFFF)  drops <= drops + 16'd1;

      if (wr_sel && (address == 3'd1)) begin
        ctrl_en <= writedata[0];
        irq_en  <= writedata[1];
      end

      if (wr_sel && ((address == 3'd4) || (address == 3'd5))) snap <= ts;
    end
  end

  // Event storage needs no reset; empty reads are masked above.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= ts;
  end

endmodule

// File: tb/tb_timer_event_logger.sv
// Bench for timer_event_logger: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_timer_event_logger;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        timer_irq;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_ts;
  logic [31:0] m_snap;
  logic [15:0] m_drops;
  logic        m_ovf;
  logic        m_en;
  logic        m_ien;
  logic        m_tprev;
  logic [15:0] m_rd;
  logic        m_irq;

  always #5 clk = ~clk;

  timer_event_logger #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .timer_irq  (timer_irq),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] r;
    logic [3:0]  n4;
    logic        e;
    logic        f;
    e  = (q.size() == 0);
    f  = (q.size() == DEPTH);
    n4 = 4'(q.size());
    r  = 16'h0000;
    case (a)
      3'd0: r = {8'h00, n4, 1'b0, m_ovf, f, e};
      3'd1: r = {14'h0000, m_ien, m_en};
      3'd2: if (!e) r = q[0][15:0];
      3'd3: if (!e) r = q[0][31:16];
      3'd4: r = m_snap[15:0];
      3'd5: r = m_snap[31:16];
      3'd6: r = m_drops;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Apply one clock of the current inputs to the model, then advance the DUT.
  task automatic step();
    logic [15:0] rd;
    logic ev, rs, ws, fl, pop, drop;
    int   n;
    n    = q.size();
    rd   = model_read(address);
    ev   = timer_irq && !m_tprev && m_en;
    rs   = chipselect && !read_n;
    ws   = chipselect && !write_n;
    fl   = ws && (address == 3'd1) && writedata[2];
    pop  = rs && (address == 3'd3) && (n > 0) && !fl;
    drop = ev && (n == DEPTH) && !pop && !fl;
    if (!reset_n) begin
      q.delete();
      m_ts = 32'h0; m_snap = 32'h0; m_drops = 16'h0;
      m_ovf = 1'b0; m_en = 1'b0; m_ien = 1'b0; m_tprev = 1'b0;
      m_rd = 16'h0; m_irq = 1'b0;
    end else begin
      m_rd  = rd;
      m_irq = m_ien && (n > 0);
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (ev && !drop) q.push_back(m_ts);
      end
      if (ws && address == 3'd0) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
      if (ws && address == 3'd6) m_drops = 16'h0;
      else if (drop && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      if (ws && address == 3'd1) begin
        m_en  = writedata[0];
        m_ien = writedata[1];
      end
      if (ws && (address == 3'd4 || address == 3'd5)) m_snap = m_ts;
      m_tprev = timer_irq;
      m_ts    = m_ts + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
    step();
    idle();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0;
    step();
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; timer_irq = 1'b0; address = 3'd0; writedata = 16'h0;
    idle();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL reset_readdata got=%h exp=0000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL reset_status got=%h exp=0001", readdata); end
  endtask

  task automatic test_capture();
    do_reset();
    bus_write(3'd1, 16'h0003);
    for (int i = 0; i < 200 && m_ts != 32'd100; i++) step();
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    step();
    step();
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0010) begin errors++; $display("FAIL capture_status got=%h exp=0010", readdata); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL capture_irq got=%b exp=1", irq); end
    bus_read(3'd2);
    checks++; if (readdata !== 16'h0064) begin errors++; $display("FAIL capture_data_l got=%h exp=0064", readdata); end
    bus_read(3'd3);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL capture_data_h got=%h exp=0000", readdata); end
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL capture_status_after got=%h exp=0001", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL capture_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus_write(3'd1, 16'h0003);
    for (int i = 0; i < 10; i++) begin
      timer_irq = 1'b1; step();
      timer_irq = 1'b0; step();
    end
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0086) begin errors++; $display("FAIL ovf_status got=%h exp=0086", readdata); end
    bus_read(3'd6);
    checks++; if (readdata !== 16'h0002) begin errors++; $display("FAIL ovf_drops got=%h exp=0002", readdata); end
    bus_write(3'd0, 16'h1234);
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0082) begin errors++; $display("FAIL ovf_cleared got=%h exp=0082", readdata); end
    bus_read(3'd6);
    checks++; if (readdata !== 16'h0002) begin errors++; $display("FAIL ovf_drops_kept got=%h exp=0002", readdata); end
  endtask

  // Continues from the full FIFO left by test_overflow.
  task automatic test_full_pop();
    logic [31:0] new_ts;
    logic [15:0] lo;
    new_ts = m_ts;
    address = 3'd3; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; timer_irq = 1'b1;
    step();
    idle();
    timer_irq = 1'b0;
    checks++; if (readdata !== m_rd) begin errors++; $display("FAIL fullpop_head got=%h exp=%h", readdata, m_rd); end
    step();
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0082) begin errors++; $display("FAIL fullpop_status got=%h exp=0082", readdata); end
    bus_read(3'd6);
    checks++; if (readdata !== 16'h0002) begin errors++; $display("FAIL fullpop_drops got=%h exp=0002", readdata); end
    lo = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(3'd2);
      lo = readdata;
      checks++; if (readdata !== m_rd) begin errors++; $display("FAIL fullpop_drain_l%0d got=%h exp=%h", i, readdata, m_rd); end
      bus_read(3'd3);
      checks++; if (readdata !== m_rd) begin errors++; $display("FAIL fullpop_drain_h%0d got=%h exp=%h", i, readdata, m_rd); end
    end
    checks++; if ({readdata, lo} !== new_ts) begin errors++; $display("FAIL fullpop_last got=%h exp=%h", {readdata, lo}, new_ts); end
  endtask

  task automatic test_flush();
    do_reset();
    bus_write(3'd1, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      timer_irq = 1'b1; step();
      timer_irq = 1'b0; step();
    end
    timer_irq = 1'b1;
    bus_write(3'd1, 16'h0007);
    timer_irq = 1'b0;
    step();
    step();
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL flush_status got=%h exp=0001", readdata); end
    bus_read(3'd6);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL flush_drops got=%h exp=0000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL flush_irq got=%b exp=0", irq); end
    bus_read(3'd1);
    checks++; if (readdata !== 16'h0003) begin errors++; $display("FAIL flush_ctrl got=%h exp=0003", readdata); end
  endtask

  task automatic test_edge_only();
    do_reset();
    bus_write(3'd1, 16'h0001);
    timer_irq = 1'b1;
    repeat (50) step();
    timer_irq = 1'b0;
    step();
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0010) begin errors++; $display("FAIL edge_status got=%h exp=0010", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_disabled got=%b exp=0", irq); end
  endtask

  task automatic test_snapshot();
    logic [31:0] snap_ts;
    do_reset();
    repeat (37) step();
    snap_ts = m_ts;
    bus_write(3'd4, 16'hBEEF);
    repeat (5) step();
    bus_read(3'd4);
    checks++; if (readdata !== snap_ts[15:0]) begin errors++; $display("FAIL snap_l got=%h exp=%h", readdata, snap_ts[15:0]); end
    bus_read(3'd5);
    checks++; if (readdata !== snap_ts[31:16]) begin errors++; $display("FAIL snap_h got=%h exp=%h", readdata, snap_ts[31:16]); end
    bus_read(3'd3);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL empty_pop got=%h exp=0000", readdata); end
    bus_read(3'd0);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL empty_status got=%h exp=0001", readdata); end
    bus_read(3'd7);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL reg7 got=%h exp=0000", readdata); end
  endtask

  task automatic test_random();
    logic [15:0] wd;
    do_reset();
    bus_write(3'd1, 16'h0003);
    for (int i = 0; i < 4000; i++) begin
      reset_n    = ($urandom_range(0, 599) != 0);
      timer_irq  = ($urandom_range(0, 2) == 0);
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 1) == 0);
      read_n     = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      write_n    = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      wd         = 16'($urandom);
      if (address == 3'd1) begin
        wd[0] = ($urandom_range(0, 7) != 0);
        wd[2] = ($urandom_range(0, 15) == 0);
      end
      writedata = wd;
      step();
      checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata cyc=%0d got=%h exp=%h", i, readdata, m_rd); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
    end
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    reset_n = 1'b0; timer_irq = 1'b0; address = 3'd0; writedata = 16'h0;
    idle();
    q.delete();
    m_ts = 32'h0; m_snap = 32'h0; m_drops = 16'h0; m_ovf = 1'b0;
    m_en = 1'b0; m_ien = 1'b0; m_tprev = 1'b0; m_rd = 16'h0; m_irq = 1'b0;
    test_reset();
    test_capture();
    test_overflow();
    test_full_pop();
    test_flush();
    test_edge_only();
    test_snapshot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
